// File: rtl/pc_seq_pkg.sv
// Shared state encodings, opcode constants and defaults for the PC sequencer.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5,
    ST_FAULT     = 3'd6
  } state_e;

  localparam logic [3:0] OP_BCOND = 4'hC;
  localparam logic [3:0] OP_JUMP  = 4'hD;

  localparam int MEM_WAIT_MAX_DEFAULT = 15;

  function automatic logic branch_taken(input logic [3:0] op, input logic cond);
    return (op == OP_JUMP) || ((op == OP_BCOND) && cond);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory handshake and Program_Counter control bundle.
interface pc_sequencer_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic               imem_rd;
  logic               imem_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  PC;
  logic               PCe;
  logic               sel_next;
  logic [ADDR_W-1:0]  branch_addr;

  modport master (
    output imem_rd, PCe, sel_next, branch_addr,
    input  imem_ready, instr, PC
  );

  modport slave (
    input  imem_rd, PCe, sel_next, branch_addr,
    output imem_ready, instr, PC
  );
endinterface

// File: rtl/pc_sequencer_branch_target_calc.sv
// Branch target: PC plus sign-extended 8-bit displacement, wrapping at ADDR_W.
module branch_target_calc #(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [7:0]        disp_i,
  output logic [ADDR_W-1:0] target_o
);
  assign target_o = pc_i + {{(ADDR_W-8){disp_i[7]}}, disp_i};
endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute/writeback sequencer driving the Program_Counter.
// Optional PC_SEQ_PERF_EN adds retired_cnt and taken_cnt performance counters.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int INSTR_W      = 16,
  parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               halt_req,
  input  logic               branch_cond,
  pc_sequencer_if.master     bus,
  output logic               ir_load,
  output logic [INSTR_W-1:0] ir,
  output logic               exec_en,
  output logic               wb_en,
  output logic [2:0]         state,
  output logic               halted,
  output logic               fault
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [15:0]        retired_cnt,
  output logic [15:0]        taken_cnt
`endif
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  baddr_q, baddr_d;
  logic [ADDR_W-1:0]  target;
  logic               taken_q, taken_d;
  logic [7:0]         wait_q, wait_d;
  logic               imem_rd_c, pce_c, sel_next_c;

  branch_target_calc #(.ADDR_W(ADDR_W)) u_target (
    .pc_i     (bus.PC),
    .disp_i   (ir_q[7:0]),
    .target_o (target)
  );

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    baddr_d    = baddr_q;
    taken_d    = taken_q;
    wait_d     = wait_q;
    imem_rd_c  = 1'b0;
    ir_load    = 1'b0;
    exec_en    = 1'b0;
    wb_en      = 1'b0;
    pce_c      = 1'b0;
    sel_next_c = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_rd_c = 1'b1;
        if (bus.imem_ready) begin
          ir_load = 1'b1;
          ir_d    = bus.instr;
          wait_d  = '0;
          state_d = ST_DECODE;
        end else begin
          // Timeout once the incremented wait count reaches the limit.
          wait_d = wait_q + 8'd1;
          if (wait_d == WAIT_LIMIT) state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        baddr_d = target;
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        exec_en = 1'b1;
        taken_d = branch_taken(ir_q[15:12], branch_cond);
        state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        wb_en      = 1'b1;
        pce_c      = 1'b1;
        sel_next_c = taken_q;
        state_d    = halt_req ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
        if (run && !halt_req) state_d = ST_FETCH;
      end
      ST_FAULT: begin
        fault = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      baddr_q <= '0;
      taken_q <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      baddr_q <= baddr_d;
      taken_q <= taken_d;
      wait_q  <= wait_d;
    end
  end

`ifdef PC_SEQ_PERF_EN
  logic [15:0] retired_q, taken_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      retired_q   <= '0;
      taken_cnt_q <= '0;
    end else if (state_q == ST_WRITEBACK) begin
      retired_q <= retired_q + 16'd1;
      if (taken_q) taken_cnt_q <= taken_cnt_q + 16'd1;
    end
  end

  assign retired_cnt = retired_q;
  assign taken_cnt   = taken_cnt_q;
`endif

  assign bus.imem_rd     = imem_rd_c;
  assign bus.PCe         = pce_c;
  assign bus.sel_next    = sel_next_c;
  assign bus.branch_addr = baddr_q;
  assign ir              = ir_q;
  assign state           = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: per-cycle behavioural model plus directed literal checks.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int AW   = 16;
  localparam int IW   = 16;
  localparam int WMAX = 15;

  logic          clk = 1'b0;
  logic          reset, run, halt_req, branch_cond;
  logic          ir_load, exec_en, wb_en, halted, fault;
  logic [IW-1:0] ir;
  logic [2:0]    state;
`ifdef PC_SEQ_PERF_EN
  logic [15:0]   retired_cnt, taken_cnt;
`endif

  pc_sequencer_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  pc_sequencer #(.ADDR_W(AW), .INSTR_W(IW), .MEM_WAIT_MAX(WMAX)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .halt_req    (halt_req),
    .branch_cond (branch_cond),
    .bus         (bus),
    .ir_load     (ir_load),
    .ir          (ir),
    .exec_en     (exec_en),
    .wb_en       (wb_en),
    .state       (state),
    .halted      (halted),
    .fault       (fault)
`ifdef PC_SEQ_PERF_EN
    ,
    .retired_cnt (retired_cnt),
    .taken_cnt   (taken_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int sel_cnt  = 0;
  int pce_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: which phase the instruction is in, what it captured, what it computed.
  logic [2:0]  m_state;
  logic [15:0] m_ir, m_baddr;
  logic        m_taken;
  int          m_wait, m_retired, m_taken_cnt;
  bit          mdl_ok = 0;

  function automatic logic [15:0] target_of(input int pc, input int disp);
    int d;
    d = (disp >= 128) ? disp - 256 : disp;
    return 16'((pc + d) & 32'hFFFF);
  endfunction

  always @(posedge clk) begin
    mdl_ok <= 1'b1;
    if (reset !== 1'b1) begin
      m_state <= 3'd0; m_ir <= '0; m_baddr <= '0; m_taken <= 1'b0;
      m_wait <= 0; m_retired <= 0; m_taken_cnt <= 0;
    end else begin
      case (m_state)
        3'd0: if (run) m_state <= 3'd1;
        3'd1: begin
          if (bus.imem_ready) begin
            m_ir <= bus.instr; m_wait <= 0; m_state <= 3'd2;
          end else begin
            m_wait <= m_wait + 1;
            if (m_wait + 1 == WMAX) m_state <= 3'd6;
          end
        end
        3'd2: begin
          m_baddr <= target_of(int'(bus.PC), int'(m_ir[7:0]));
          m_state <= 3'd3;
        end
        3'd3: begin
          m_taken <= (m_ir[15:12] == 4'hD) || (m_ir[15:12] == 4'hC && branch_cond);
          m_state <= 3'd4;
        end
        3'd4: begin
          m_retired <= (m_retired + 1) % 65536;
          if (m_taken) m_taken_cnt <= (m_taken_cnt + 1) % 65536;
          m_state <= halt_req ? 3'd5 : 3'd1;
        end
        3'd5: if (run && !halt_req) m_state <= 3'd1;
        default: m_state <= m_state;
      endcase
    end
  end

  always @(negedge clk) begin
    if (mdl_ok) begin
      cyc++;
      chk("cycle_outputs",
          {21'd0, state, bus.imem_rd, ir_load, exec_en, wb_en, bus.PCe, bus.sel_next, halted, fault, ir, bus.branch_addr},
          {21'd0, m_state, m_state == 3'd1, (m_state == 3'd1) && bus.imem_ready, m_state == 3'd3,
           m_state == 3'd4, m_state == 3'd4, (m_state == 3'd4) && m_taken, m_state == 3'd5, m_state == 3'd6,
           m_ir, m_baddr});
`ifdef PC_SEQ_PERF_EN
      chk("retired_cnt", {48'd0, retired_cnt}, 64'(m_retired));
      chk("taken_cnt", {48'd0, taken_cnt}, 64'(m_taken_cnt));
`endif
      if (bus.PCe === 1'b1) begin
        pce_q.push_back(cyc);
        if (bus.sel_next === 1'b1) sel_cnt++;
        $display("txn retire cyc=%0d sel_next=%0d branch_addr=%04h ir=%04h",
                 cyc, bus.sel_next, bus.branch_addr, ir);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Start from IDLE/HALT, raise halt_req in EXECUTE, check the retiring writeback and HALT.
  task automatic run_one(input logic [15:0] ins, input logic [15:0] pc, input logic cond,
                         input logic exp_sel, input logic [15:0] exp_ba, input string nm);
    halt_req = 1'b0; run = 1'b1; bus.instr = ins; bus.PC = pc; branch_cond = cond;
    step(1);
    chk({nm, "_fetch"}, 64'(state), 64'd1);
    run = 1'b0;
    step(2);
    chk({nm, "_execute"}, 64'(state), 64'd3);
    halt_req = 1'b1;
    step(1);
    chk({nm, "_wb"}, 64'({bus.PCe, wb_en, bus.sel_next}), 64'({1'b1, 1'b1, exp_sel}));
    chk({nm, "_baddr"}, 64'(bus.branch_addr), 64'(exp_ba));
    step(1);
    chk({nm, "_halt"}, 64'({state, halted, bus.PCe}), 64'({3'd5, 1'b1, 1'b0}));
    $display("txn %s instr=%04h pc=%04h cond=%0d", nm, ins, pc, cond);
  endtask

  initial begin
    int n0;
    reset = 1'b0; run = 1'b0; halt_req = 1'b0; branch_cond = 1'b0;
    bus.imem_ready = 1'b0; bus.instr = '0; bus.PC = '0;
    step(2);
    reset = 1'b1;
    step(1);
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_outs", 64'({bus.imem_rd, ir_load, exec_en, wb_en, bus.PCe, bus.sel_next, halted, fault}), 64'd0);
    chk("reset_ir", 64'(ir), 64'd0);
    chk("reset_baddr", 64'(bus.branch_addr), 64'd0);

    // Three sequential instructions with zero-wait memory.
    run = 1'b1; bus.imem_ready = 1'b1; bus.instr = 16'h1234; bus.PC = 16'h0000;
    step(1);
    chk("run_to_fetch", 64'(state), 64'd1);
    run = 1'b0; pce_q.delete(); sel_cnt = 0;
    step(10);
    halt_req = 1'b1;
    step(1);
    chk("seq_third_pce", 64'(bus.PCe), 64'd1);
    step(1);
    chk("seq_halted", 64'({state, halted}), 64'({3'd5, 1'b1}));
    chk("seq_pce_count", 64'(pce_q.size()), 64'd3);
    if (pce_q.size() == 3) begin
      chk("seq_pce_gap1", 64'(pce_q[1] - pce_q[0]), 64'd4);
      chk("seq_pce_gap2", 64'(pce_q[2] - pce_q[1]), 64'd4);
    end
    chk("seq_sel_next", 64'(sel_cnt), 64'd0);
`ifdef PC_SEQ_PERF_EN
    chk("seq_retired_lit", 64'(retired_cnt), 64'd3);
`endif

    run_one(16'hC0FE, 16'h0010, 1'b1, 1'b1, 16'h000E, "bcond_taken");
    run_one(16'hC0FE, 16'h0010, 1'b0, 1'b0, 16'h000E, "bcond_not");
    run_one(16'hD0FC, 16'h0002, 1'b0, 1'b1, 16'hFFFE, "jump_wrap");
    run_one(16'h3005, 16'h0100, 1'b1, 1'b0, 16'h0105, "seq_cond_hi");

    // Resume from HALT, then reset in EXECUTE.
    run = 1'b1; halt_req = 1'b0; bus.instr = 16'h1234;
    step(1);
    chk("halt_resume", 64'(state), 64'd1);
    run = 1'b0;
    step(2);
    chk("pre_reset_exec", 64'(state), 64'd3);
    reset = 1'b0;
    n0 = pce_q.size();
    step(1);
    chk("reset_exec_state", 64'(state), 64'd0);
    chk("reset_exec_ir", 64'(ir), 64'd0);
    chk("reset_exec_pce", 64'(bus.PCe), 64'd0);
    chk("reset_exec_no_pulse", 64'(pce_q.size()), 64'(n0));
    reset = 1'b1;
    step(1);

    // Fetch timeout.
    bus.imem_ready = 1'b0; run = 1'b1;
    step(1);
    run = 1'b0;
    step(14);
    chk("fetch_wait14", 64'(state), 64'd1);
    step(1);
    chk("fault_state", 64'({state, fault}), 64'({3'd6, 1'b1}));
    run = 1'b1; bus.imem_ready = 1'b1;
    step(5);
    chk("fault_sticky", 64'({state, fault, bus.PCe}), 64'({3'd6, 1'b1, 1'b0}));
    run = 1'b0; reset = 1'b0;
    step(1);
    chk("fault_cleared", 64'({state, fault}), 64'd0);
    reset = 1'b1;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Control FSM that sequences the Program_Counter through fetch, decode, execute and writeback for each instruction.
- Generates the one-cycle PCe pulse, and sel_next/branch_addr for branch loads.
- Handshakes instruction fetch with instruction memory and latches the instruction register.
- Sits between Program_Counter, instruction memory and the execute datapath (ALU/regfile enables).

Parameters:
ADDR_W, 16, PC/branch address width
INSTR_W, 16, instruction width
MEM_WAIT_MAX, 15, max FETCH wait cycles before fault (range 1..255)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
run  in  1  start from IDLE / resume from HALT
halt_req  in  1  stop after current instruction
imem_ready  in  1  instr valid; may assert in same cycle as imem_rd
instr  in  INSTR_W  instruction memory read data
branch_cond  in  1  condition flag, sampled in EXECUTE
PC  in  ADDR_W  current PC from Program_Counter
PCe  out  1  PC update enable, one-cycle pulse
sel_next  out  1  1 = PC loads branch_addr, 0 = PC+1
branch_addr  out  ADDR_W  registered branch target
imem_rd  out  1  instruction read request
ir_load  out  1  pulse when ir captures instr
ir  out  INSTR_W  instruction register
exec_en  out  1  execute-stage enable
wb_en  out  1  writeback enable
state  out  3  current state encoding
halted  out  1  high in HALT
fault  out  1  sticky fetch timeout flag

Behaviour:
- Reset (reset==0 at posedge): state=IDLE. All outputs 0, including ir, branch_addr and the wait counter. Reset overrides every state, including mid-fetch and mid-writeback; no PCe is issued in the reset cycle.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5, FAULT=6.
- IDLE: run=1 -> FETCH.
- FETCH:
  - imem_rd=1.
  - imem_ready=1 -> ir<=instr, ir_load=1 for that cycle, wait counter cleared, go to DECODE.
  - Otherwise the wait counter increments. If the counter equals MEM_WAIT_MAX and ready is still 0 -> FAULT.
- DECODE (1 cycle):
  - branch_addr <= PC + sext(ir[7:0]), modulo 2^ADDR_W (wraps, e.g. 0x0002 + 0xFC -> 0xFFFE).
  - Opcode ir[15:12]: 4'hC = conditional branch, 4'hD = unconditional branch, any other value = sequential.
- EXECUTE (1 cycle): exec_en=1; taken <= (op==4'hD) | (op==4'hC & branch_cond).
- WRITEBACK (1 cycle):
  - wb_en=1, PCe=1, sel_next=taken.
  - halt_req=1 -> HALT, else FETCH.
- HALT: halted=1, PCe=0. run=1 & halt_req=0 -> FETCH; otherwise stay.
- FAULT: fault=1, sticky. Exit only via reset.
- Throughput: 4 cycles/instr with zero-wait memory; +1 cycle per imem_ready wait cycle.
- halt_req is sampled only in WRITEBACK, so the current instruction always completes and updates the PC.
- Exactly one PCe pulse per retired instruction; PCe never asserts outside WRITEBACK.
- run is ignored outside IDLE/HALT.

Optional Feature:
PC_SEQ_PERF_EN:
- Defined: adds output retired_cnt[15:0], reset to 0, +1 on each WRITEBACK, wraps 0xFFFF->0x0000.
- Also adds taken_cnt[15:0], incremented in WRITEBACK when sel_next=1.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package pc_seq_pkg: state encodings, opcode constants OP_BCOND=4'hC and OP_JUMP=4'hD, default MEM_WAIT_MAX.
- One sub-module, branch_target_calc: combinational PC + sign-extended 8-bit displacement, wrapping at ADDR_W.
- FSM and registers stay in pc_sequencer.

Test Plan:
- Reset low 2 cycles, then high with run=0 -> state=0 and all outputs 0. Pulse run -> FETCH next cycle.
- Zero-wait memory, 3 non-branch instrs (0x1234) -> PCe pulses exactly every 4 cycles, sel_next=0, retired_cnt=3.
- PC=0x0010, ir=0xC0FE, branch_cond=1 -> branch_addr=0x000E and sel_next=1 with PCe. Same with branch_cond=0 -> sel_next=0.
- PC=0x0002, instr=0xD0FC -> branch_addr=0xFFFE (wrap). Separately, imem_ready held 0 for 15 cycles -> FAULT and fault=1 until reset.
- halt_req=1 during EXECUTE -> WRITEBACK still pulses PCe, then HALT with halted=1. run=1, halt_req=0 -> FETCH.
- Reset low in EXECUTE -> next state IDLE, no PCe, ir=0.
